// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory read bus between the fetch unit and the
//               instruction memory.
//                 imem_req_out  - read request (held high while waiting)
//                 imem_addr_out - read address (stable while requested)
//                 imem_ack_in   - read acknowledge, data valid this cycle
//                 imem_data_in  - read data
//               The master modport is the fetch unit side. The slave modport
//               is the memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic        imem_req_out;
    logic [15:0] imem_addr_out;
    logic        imem_ack_in;
    logic [15:0] imem_data_in;

    modport master (
        output imem_req_out,
        output imem_addr_out,
        input  imem_ack_in,
        input  imem_data_in
    );

    modport slave (
        input  imem_req_out,
        input  imem_addr_out,
        output imem_ack_in,
        output imem_data_in
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch unit. It holds the program counter and the
//               instruction register. A two-state FSM (F_IDLE/F_WAIT) issues
//               one read to instruction memory for each il_in request. The PC
//               changes only while idle: hold, +1, branch-relative using a
//               6-bit signed IR field, or a jump to a_in.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               il_in           - instruction-load request
//               ps_in[1:0]      - PC select (00 hold, 01 inc, 10 branch, 11 jump)
//               a_in[15:0]      - jump target
//               ins_out[15:0]   - instruction register
//               pc_out[15:0]    - program counter
//               ins_vld_out     - one-cycle pulse when a new instruction is in ins_out
//               busy_out        - fetch in progress
//               timeout_out     - sticky fetch-timeout flag
//               imem            - instruction memory bus (master)
// Options     : FETCH_TIMEOUT_EN - when this macro is defined, a fetch is
//               abandoned after 15 wait cycles with no acknowledge. The unit
//               then returns FFFF and sets timeout_out.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        il_in,
    input  wire logic [1:0]  ps_in,
    input  wire logic [15:0] a_in,
    output logic      [15:0] ins_out,
    output logic      [15:0] pc_out,
    output logic             ins_vld_out,
    output logic             busy_out,
    output logic             timeout_out,
    fetch_unit_if.master     imem
);

    typedef enum logic [0:0] {
        F_IDLE = 1'b0,
        F_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] r_ir;
    logic [15:0] w_ir_nxt;
    logic [15:0] r_addr;
    logic [15:0] w_addr_nxt;
    logic        r_vld;
    logic        w_vld_nxt;
    logic [15:0] w_br_off;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0] c_TIMEOUT_LAST = 4'd14; // wait count during the 15th F_WAIT cycle
    localparam logic [15:0] c_ILLEGAL_OP  = 16'hFFFF;
    logic [3:0]  r_wcnt;
    logic [3:0]  w_wcnt_nxt;
    logic        r_timeout;
    logic        w_timeout_nxt;
`endif

    // The branch offset is split across IR[8:6] and IR[2:0]. It is
    // sign-extended from bit 5 of the joined field.
    assign w_br_off = {{10{r_ir[8]}}, r_ir[8:6], r_ir[2:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_addr_nxt  = r_addr;
        w_vld_nxt   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        w_wcnt_nxt    = r_wcnt;
        w_timeout_nxt = r_timeout;
`endif
        case (r_state)
            F_IDLE: begin
                // The fetch address is taken from the PC before this cycle's update.
                if (il_in) begin
                    w_addr_nxt  = r_pc;
                    w_state_nxt = F_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    w_wcnt_nxt  = 4'd0;
`endif
                end
                case (ps_in)
                    2'b01:   w_pc_nxt = r_pc + 16'd1;
                    2'b10:   w_pc_nxt = r_pc + w_br_off;
                    2'b11:   w_pc_nxt = a_in;
                    default: w_pc_nxt = r_pc;
                endcase
            end
            F_WAIT: begin
                // An acknowledge wins over a timeout in the same cycle.
                if (imem.imem_ack_in) begin
                    w_ir_nxt    = imem.imem_data_in;
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = F_IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (r_wcnt == c_TIMEOUT_LAST) begin
                    w_ir_nxt      = c_ILLEGAL_OP;
                    w_vld_nxt     = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = F_IDLE;
                end else begin
                    w_wcnt_nxt = r_wcnt + 4'd1;
                end
`endif
            end
            default: w_state_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= F_IDLE;
            r_pc    <= 16'h0000;
            r_ir    <= 16'h0000;
            r_addr  <= 16'h0000;
            r_vld   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_wcnt    <= 4'd0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_addr  <= w_addr_nxt;
            r_vld   <= w_vld_nxt;
`ifdef FETCH_TIMEOUT_EN
            r_wcnt    <= w_wcnt_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    assign ins_out            = r_ir;
    assign pc_out             = r_pc;
    assign ins_vld_out        = r_vld;
    assign busy_out           = (r_state == F_WAIT);
    assign imem.imem_req_out  = (r_state == F_WAIT);
    assign imem.imem_addr_out = r_addr;
`ifdef FETCH_TIMEOUT_EN
    assign timeout_out        = r_timeout;
`else
    assign timeout_out        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard testbench for fetch_unit. Each stimulus fetch
//               pushes its expected instruction into a queue. A monitor
//               process pops one entry and compares it on every ins_vld_out
//               pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        il_in;
    logic [1:0]  ps_in;
    logic [15:0] a_in;
    logic [15:0] ins_out;
    logic [15:0] pc_out;
    logic        ins_vld_out;
    logic        busy_out;
    logic        timeout_out;

    fetch_unit_if imem ();

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .il_in       (il_in),
        .ps_in       (ps_in),
        .a_in        (a_in),
        .ins_out     (ins_out),
        .pc_out      (pc_out),
        .ins_vld_out (ins_vld_out),
        .busy_out    (busy_out),
        .timeout_out (timeout_out),
        .imem        (imem)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ins_vld_out pulse must match the oldest expected instruction.
    always @(negedge clk) begin
        if (ins_vld_out) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_vld: got ins_out %h expected no pulse", ins_out);
            end else begin
                logic [15:0] exp_ins;
                exp_ins = sb_q.pop_front();
                if (ins_out !== exp_ins) begin
                    n_fail++;
                    $display("FAIL ins_out: got %h expected %h", ins_out, exp_ins);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete fetch. ps_first is applied in the il_in cycle. ps_wait and
    // a_wait are applied through the wait cycles and must have no effect.
    task automatic do_fetch(input logic [15:0] exp_addr, input logic [15:0] data,
                            input int delay, input logic [1:0] ps_first,
                            input logic [1:0] ps_wait, input logic [15:0] a_wait,
                            input logic [15:0] exp_pc);
        sb_q.push_back(data);
        il_in = 1'b1;
        ps_in = ps_first;
        tick();
        il_in = 1'b0;
        ps_in = ps_wait;
        a_in  = a_wait;
        chk("req_high", {15'd0, imem.imem_req_out}, 16'h0001);
        chk("fetch_addr", imem.imem_addr_out, exp_addr);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("addr_stable", imem.imem_addr_out, exp_addr);
        end
        imem.imem_ack_in  = 1'b1;
        imem.imem_data_in = data;
        tick();
        imem.imem_ack_in  = 1'b0;
        imem.imem_data_in = 16'h0000;
        ps_in = 2'b00;
        chk("busy_after_ack", {15'd0, busy_out}, 16'h0000);
        chk("pc_after_fetch", pc_out, exp_pc);
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; il_in = 1'b0; ps_in = 2'b00; a_in = 16'h0000;
        imem.imem_ack_in = 1'b0; imem.imem_data_in = 16'h0000;
        tick(); tick();
        // Reset state.
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_ir", ins_out, 16'h0000);
        chk("rst_addr", imem.imem_addr_out, 16'h0000);
        chk("rst_flags", {11'd0, ins_vld_out, busy_out, imem.imem_req_out, timeout_out, 1'b0}, 16'h0000);
        rst = 1'b0;
        tick();

        // Fetch at PC 0 with minimum latency. 01C7 gives an offset field of 111111 (-1).
        do_fetch(16'h0000, 16'h01C7, 0, 2'b00, 2'b00, 16'h0000, 16'h0000);
        ps_in = 2'b10; tick(); ps_in = 2'b00;
        chk("branch_neg_wrap", pc_out, 16'hFFFF);
        ps_in = 2'b01; tick(); ps_in = 2'b00;
        chk("inc_wrap", pc_out, 16'h0000);

        // Jump to 0010, then fetch 1234 with an ack after 3 wait cycles.
        ps_in = 2'b11; a_in = 16'h0010; tick(); ps_in = 2'b00;
        chk("jump_0010", pc_out, 16'h0010);
        do_fetch(16'h0010, 16'h1234, 3, 2'b00, 2'b00, 16'h0000, 16'h0010);
        chk("ir_1234", ins_out, 16'h1234);
        // For IR 1234 the offset field is 000100 (+4).
        ps_in = 2'b10; tick(); ps_in = 2'b00;
        chk("branch_pos", pc_out, 16'h0014);

        // il_in and increment in the same cycle at PC 0040.
        ps_in = 2'b11; a_in = 16'h0040; tick(); ps_in = 2'b00;
        do_fetch(16'h0040, 16'hBEEF, 1, 2'b01, 2'b00, 16'h0000, 16'h0041);

        // A jump request during F_WAIT is ignored. The same request in F_IDLE takes effect.
        do_fetch(16'h0041, 16'h0F0F, 2, 2'b00, 2'b11, 16'hABCD, 16'h0041);
        ps_in = 2'b11; a_in = 16'hABCD; tick(); ps_in = 2'b00;
        chk("jump_abcd", pc_out, 16'hABCD);

        // Reset during F_WAIT, then a late ack must not load IR.
        il_in = 1'b1; tick(); il_in = 1'b0;
        chk("busy_before_rst", {15'd0, busy_out}, 16'h0001);
        rst = 1'b1; tick(); rst = 1'b0;
        imem.imem_ack_in = 1'b1; imem.imem_data_in = 16'h5555; tick();
        imem.imem_ack_in = 1'b0; imem.imem_data_in = 16'h0000;
        chk("rst_abort_ir", ins_out, 16'h0000);
        chk("rst_abort_busy", {15'd0, busy_out}, 16'h0000);
        chk("rst_abort_pc", pc_out, 16'h0000);
        tick();
        chk("rst_abort_ir2", ins_out, 16'h0000);

`ifdef FETCH_TIMEOUT_EN
        // No ack: after the 15th wait cycle IR is FFFF and timeout_out is sticky.
        sb_q.push_back(16'hFFFF);
        il_in = 1'b1; tick(); il_in = 1'b0;
        repeat (14) tick();
        chk("to_still_wait", {14'd0, busy_out, timeout_out}, 16'h0002);
        tick();
        chk("to_ir", ins_out, 16'hFFFF);
        chk("to_flags", {14'd0, busy_out, timeout_out}, 16'h0001);
        repeat (5) tick();
        chk("to_sticky", {15'd0, timeout_out}, 16'h0001);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("to_cleared", {15'd0, timeout_out}, 16'h0000);
`else
        // Without the timeout option, the unit waits indefinitely until reset.
        il_in = 1'b1; tick(); il_in = 1'b0;
        repeat (20) tick();
        chk("nto_wait", {14'd0, busy_out, timeout_out}, 16'h0002);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("nto_abort", {15'd0, busy_out}, 16'h0000);
`endif
        tick(); tick();
        chk("sb_drained", 16'(sb_q.size()), 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port il_in, input, 1 bit: instruction-load request from control unit.
REQ-004 SHALL have port ps_in, input, 2 bits: PC select; 00 hold, 01 increment, 10 branch relative, 11 jump.
REQ-005 SHALL have port a_in, input, 16 bits: jump target (register A value).
REQ-006 SHALL have port ins_out, output, 16 bits: instruction register contents, to control unit.
REQ-007 SHALL have port pc_out, output, 16 bits: current program counter.
REQ-008 SHALL have port ins_vld_out, output, 1 bit: one-cycle pulse, new instruction in ins_out.
REQ-009 SHALL have port busy_out, output, 1 bit: fetch in progress.
REQ-010 SHALL have port imem_req_out, output, 1 bit: instruction memory read request.
REQ-011 SHALL have port imem_addr_out, output, 16 bits: instruction memory address.
REQ-012 SHALL have port imem_ack_in, input, 1 bit: memory read acknowledge, data valid.
REQ-013 SHALL have port imem_data_in, input, 16 bits: memory read data.
REQ-014 SHALL have port timeout_out, output, 1 bit: sticky fetch-timeout flag.

Function
REQ-015 SHALL implement fetch FSM with states F_IDLE and F_WAIT; busy_out = imem_req_out = (state == F_WAIT).
REQ-016 SHALL, in F_IDLE with il_in=1, register imem_addr_out <= pc_out and enter F_WAIT (req high next cycle).
REQ-017 SHALL hold imem_addr_out stable for the whole of F_WAIT.
REQ-018 SHALL, in F_WAIT with imem_ack_in=1, load IR <= imem_data_in, pulse ins_vld_out next cycle, return to F_IDLE; minimum fetch latency il_in to ins_vld_out = 2 cycles.
REQ-019 SHALL ignore imem_ack_in in F_IDLE and il_in in F_WAIT.
REQ-020 SHALL update PC only in F_IDLE: 01 PC+1; 10 PC + sign-extended 6-bit {IR[8:6],IR[2:0]}; 11 PC <= a_in; 00 hold.
REQ-021 SHALL ignore ps_in != 00 while in F_WAIT (PC unchanged).
REQ-022 SHALL, when il_in=1 and ps_in != 00 in same F_IDLE cycle, fetch from pre-update PC and apply PC update in that same cycle.
REQ-023 SHALL wrap all PC arithmetic modulo 2^16 (FFFF+1 = 0000; 0000 + (-1) = FFFF).
REQ-024 SHALL drive ins_out and pc_out directly from registers (no combinational path from inputs).

Reset
REQ-025 SHALL on rst=1 set PC=0000, IR=0000, imem_addr_out=0000, state F_IDLE, ins_vld_out=0, busy_out=0, imem_req_out=0, timeout_out=0.
REQ-026 SHALL abort an in-progress fetch on reset; an imem_ack_in arriving during or after reset SHALL NOT load IR.
REQ-027 SHALL give rst priority over all other inputs in the same cycle.

Configuration
REQ-028 SHALL use macro FETCH_TIMEOUT_EN; when defined, a 4-bit wait counter counts F_WAIT cycles; on 15th F_WAIT cycle without ack, IR <= FFFF (illegal opcode, control unit halts), ins_vld_out pulses, timeout_out sets and stays 1 until reset, FSM returns to F_IDLE.
REQ-029 SHALL, with FETCH_TIMEOUT_EN undefined, wait in F_WAIT indefinitely and tie timeout_out to 0.
REQ-030 SHALL, with FETCH_TIMEOUT_EN defined, give ack priority over timeout when both occur in same cycle.

Verification
REQ-031 SHALL cover: PC=0010, il_in=1, ack after 3 wait cycles with data 1234 -> imem_addr_out=0010, ins_out=1234, one ins_vld_out pulse.
REQ-032 SHALL cover: IR offset field = 111111 (-1), PC=0000, ps_in=10 -> PC=FFFF; PC=FFFF, ps_in=01 -> PC=0000.
REQ-033 SHALL cover: il_in=1 and ps_in=01 together at PC=0040 -> fetch address 0040, PC=0041.
REQ-034 SHALL cover: ps_in=11, a_in=ABCD during F_WAIT -> PC unchanged; same in F_IDLE -> PC=ABCD.
REQ-035 SHALL cover: rst=1 in F_WAIT, ack with data 5555 next cycle -> IR=0000, no ins_vld_out pulse.
REQ-036 SHALL cover (FETCH_TIMEOUT_EN): no ack for 15 cycles -> IR=FFFF, timeout_out=1 held until rst.
